// File: rtl/vxe_vpu_vagen.sv
// vxe_vpu_vagen: vector address generator.
// Turns a vector descriptor (base element address, length, stride) into a
// stream of bus-word addresses with per-element lane-enable masks. One beat
// is presented per consume handshake. Packed, strided and broadcast modes
// are supported, with last, done and flush signalling.
module vxe_vpu_vagen #(
  parameter int ADDR_W   = 38,
  parameter int LEN_W    = 20,
  parameter int EPW_LOG2 = 1
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [ADDR_W-1:0]          i_vaddr,
  input  logic [LEN_W-1:0]           i_vlen,
  input  logic [LEN_W-1:0]           i_stride,
  input  logic                       i_latch,
  input  logic                       i_incr,
  input  logic                       i_flush,
  output logic                       o_valid,
  output logic [ADDR_W-EPW_LOG2-1:0] o_addr,
  output logic [(1<<EPW_LOG2)-1:0]   o_we_mask,
  output logic                       o_last,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int EPW = 1 << EPW_LOG2;

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {MODE_PACKED, MODE_STRIDED, MODE_BCAST} mode_t;

  state_t                     state_q, state_d;
  mode_t                      mode_q, mode_d;
  logic [ADDR_W-1:0]          ea_q, ea_d;
  logic [LEN_W-1:0]           rem_q, rem_d;
  logic [LEN_W-1:0]           stride_q, stride_d;
  logic [ADDR_W-EPW_LOG2-1:0] addr_q, addr_d;
  logic [EPW-1:0]             mask_q, mask_d;
  logic                       last_q, last_d;
  logic                       done_q, done_d;
  logic [LEN_W-1:0]           n_cur;
  logic [3:0]                 off_d;

  // Lane mask for a beat: a contiguous run from the element offset in packed
  // mode (clipped by the remaining count and the word end), otherwise a
  // single lane at the element offset.
  function automatic logic [EPW-1:0] beat_mask(input logic [3:0] off,
                                               input logic [LEN_W-1:0] rem,
                                               input mode_t mode);
    logic [LEN_W:0] lim;
    logic [EPW-1:0] m;
    lim = {1'b0, rem} + (LEN_W+1)'(off);
    m   = '0;
    for (int i = 0; i < EPW; i++) begin
      if (mode == MODE_PACKED) begin
        m[i] = (4'(i) >= off) && ((LEN_W+1)'(i) < lim);
      end else begin
        m[i] = (4'(i) == off);
      end
    end
    return m;
  endfunction

  // Number of elements covered by a mask.
  function automatic logic [LEN_W-1:0] popcount(input logic [EPW-1:0] m);
    logic [LEN_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < EPW; i++) begin
      cnt = cnt + LEN_W'(m[i]);
    end
    return cnt;
  endfunction

  // Next-state logic: flush beats latch beats consume; the next beat's
  // outputs are computed here so every output leaves a flop.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    ea_d     = ea_q;
    rem_d    = rem_q;
    stride_d = stride_q;
    done_d   = 1'b0;
    n_cur    = popcount(mask_q);

    if (i_flush) begin
      state_d = IDLE;
    end else if (i_latch) begin
      ea_d     = i_vaddr;
      rem_d    = i_vlen;
      stride_d = i_stride;
      if (i_stride == LEN_W'(1)) begin
        mode_d = MODE_PACKED;
      end else if (i_stride == '0) begin
        mode_d = MODE_BCAST;
      end else begin
        mode_d = MODE_STRIDED;
      end
      if (i_vlen == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (i_incr && (state_q == RUN)) begin
      if (mode_q == MODE_PACKED) begin
        ea_d  = ea_q + ADDR_W'(n_cur);
        rem_d = rem_q - n_cur;
      end else begin
        ea_d  = ea_q + ADDR_W'(stride_q);
        rem_d = rem_q - LEN_W'(1);
      end
      if (last_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end

    off_d  = ea_d[3:0] & 4'(EPW - 1);
    addr_d = ea_d[ADDR_W-1:EPW_LOG2];
    mask_d = (state_d == RUN) ? beat_mask(off_d, rem_d, mode_d) : '0;
    last_d = (state_d == RUN) && (popcount(mask_d) == rem_d);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      mode_q   <= MODE_PACKED;
      ea_q     <= '0;
      rem_q    <= '0;
      stride_q <= '0;
      addr_q   <= '0;
      mask_q   <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      ea_q     <= ea_d;
      rem_q    <= rem_d;
      stride_q <= stride_d;
      addr_q   <= addr_d;
      mask_q   <= mask_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign o_valid   = (state_q == RUN);
  assign o_busy    = (state_q == RUN);
  assign o_addr    = addr_q;
  assign o_we_mask = mask_q;
  assign o_last    = last_q;
  assign o_done    = done_q;

endmodule

// File: doc/vxe_vpu_vagen.md
# vxe_vpu_vagen

Parametrised vector address generator for the VPU execution units. It converts a vector descriptor (element base address, length, element stride) into a sequence of bus-word addresses with per-element write/lane-enable masks, one beat per consume handshake. Generalises the fixed two-elements-per-word product-unit generator in three ways: configurable elements per word, strided and broadcast access modes, and explicit last/done/flush signalling. It sits between the VPU instruction sequencer (descriptor, `i_latch`) and the load/store ports of the execution units (`i_incr` consumer).

## Interface

- `ADDR_W`, 38: element address width, in 32-bit element units.
- `LEN_W`, 20: vector length and stride width.
- `EPW_LOG2`, 1: log2 of elements per bus word. `EPW = 2**EPW_LOG2`, range 1..8.

- `clk`  in  1  clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `i_vaddr`  in  ADDR_W  element base address.
- `i_vlen`  in  LEN_W  number of elements; 0 is legal.
- `i_stride`  in  LEN_W  element stride, unsigned. 1 selects packed mode, 0 selects broadcast, any other value selects strided mode.
- `i_latch`  in  1  load the descriptor and start a sequence.
- `i_incr`  in  1  consume the current beat.
- `i_flush`  in  1  abort the current sequence.
- `o_valid`  out  1  current beat valid.
- `o_addr`  out  ADDR_W-EPW_LOG2  bus-word address.
- `o_we_mask`  out  EPW  element enable. Bit i selects element i of the word (element address low bits == i).
- `o_last`  out  1  current beat is the final beat.
- `o_busy`  out  1  sequence in progress (equals `o_valid`).
- `o_done`  out  1  one-cycle pulse when a sequence completes.

## Operation

- **State:**
  - `IDLE`: no valid beat.
  - `RUN`: a beat is presented.
  - Registers: current element address `ea` (ADDR_W), remaining count `rem` (LEN_W), latched stride, latched mode.
- **Latch:**
  - Captures `i_vaddr` into `ea`, `i_vlen` into `rem`, and the stride and mode.
  - If `i_vlen == 0`: stay or return to `IDLE`, `o_valid = 0`, `o_done` pulses.
  - Otherwise: enter `RUN`.
- **Beat outputs:**
  - `o_addr = ea[ADDR_W-1:EPW_LOG2]`.
  - `off = ea[EPW_LOG2-1:0]`.
- **Packed mode:**
  - Mask bits `off .. min(off+rem, EPW)-1` are set.
  - `n = popcount(mask)`.
  - On consume: `ea += n` (which realigns to the next word boundary), `rem -= n`.
- **Strided mode:**
  - Mask is one-hot at bit `off`.
  - On consume: `ea += stride`, `rem -= 1`.
- **Broadcast mode (stride 0):**
  - Mask is one-hot at bit `off`, and `ea` is unchanged.
  - On consume: `rem -= 1`.
- **`o_last`:** asserted when the consumed amount equals `rem` (packed: `n == rem`; other modes: `rem == 1`).
- **Consume:**
  - A consume occurs when `i_incr && o_valid`.
  - Consuming the last beat moves the block to `IDLE` and pulses `o_done` in the next cycle.
  - `i_incr` while `!o_valid` is ignored.
- **Arithmetic:**
  - `ea` wraps modulo 2^ADDR_W; the address wraps silently with no error.
  - `rem` never underflows.
- **Priority:** flush > latch > incr.
  - Flush returns the block to `IDLE` without pulsing `o_done`.
  - Latch while `RUN` discards the old sequence and restarts. No `o_done` pulses for the discarded sequence.
- **Descriptor inputs** are sampled only on `i_latch`; they may change freely otherwise.

## Timing

- All outputs are registered.
- **Reset values:** `o_valid = 0`, `o_addr = 0`, `o_we_mask = 0`, `o_last = 0`, `o_busy = 0`, `o_done = 0`. Reset mid-sequence abandons the sequence immediately.
- **Latency:**
  - `i_latch` at edge k gives the first beat on the outputs after edge k, so it is visible at edge k+1.
  - Zero-length latch at edge k gives `o_done = 1` for the cycle after edge k.
- **Throughput:**
  - Continuous `i_incr` consumes one beat per clock with no bubbles.
  - The next beat is visible the cycle after each consume.
- **Held outputs:** `o_addr`, `o_we_mask` and `o_last` hold while `o_valid && !i_incr`.
- **Completion and restart:**
  - Last-beat consume at edge k gives `o_valid = 0` and `o_done = 1` after edge k.
  - Latch at edge k+1 is accepted normally, giving back-to-back sequences.
- **Invalid beats:** when `o_valid = 0`, `o_we_mask = 0` and `o_last = 0`.

## Test plan

All tests use default parameters unless stated.

1. **Packed, unaligned.** `vaddr=0x101`, `vlen=8`, stride 1, `incr` held. Required beats (addr/mask): 0x80/10, 0x81/11, 0x82/11, 0x83/11, 0x84/01. `o_last` on beat 5; `o_done` pulses one cycle later.
2. **Packed, aligned, with stalls.** `vaddr=0x100`, `vlen=1`, then `vaddr=0x100`, `vlen=8` with `incr` toggled every other cycle.
   - First sequence: single beat 0x80/01 with `o_last`.
   - Second sequence: 0x80..0x83, all mask 11, each beat held stable while `incr=0`.
3. **Strided and broadcast.**
   - `vaddr=0x10`, `vlen=3`, stride 5 → 0x08/01, 0x0A/10, 0x0D/01.
   - Stride 0, `vaddr=0x7`, `vlen=3` → three beats of 0x03/10.
4. **Edge descriptors.**
   - `vlen=0` → `o_valid` never rises; `o_done` pulses one cycle after latch.
   - `vaddr=0x3FFFFFFFFF`, `vlen=2` → 0x1FFFFFFFFF/10 then 0x0000000000/01 (address wraps).
5. **Priority.**
   - Latch a new descriptor mid-sequence → old beats stop, new first beat appears next cycle, no `o_done` for the old sequence.
   - `i_flush` with `i_latch` in the same cycle → `IDLE`, no `o_done`.
   - Asserting `nrst` mid-sequence → all outputs 0 immediately.
6. **Parameter sweep.** `EPW_LOG2 = 0, 2, 3` with `vaddr=0x5`, `vlen=10`, packed.
   - `EPW_LOG2=2` beats: 0x1/1110, 0x2/1111, 0x3/0111.
   - For every `EPW_LOG2`: the popcount of masks sums to 10.
